// File: rtl/delay_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : delay_buf_pkg                                              |
// | Desc    : Shared FSM state type and default widths for the           |
// |           delay_buffer_ctrl circular-buffer delay line.              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package delay_buf_pkg;

    localparam int c_ADDRESS_WIDTH = 9;
    localparam int c_DATA_WIDTH    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/delay_buffer_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : delay_buffer_ctrl_if                                     |
// | Desc      : Sample-strobe / delayed-sample bundle of the delay line. |
// |             master = sample source side, slave = delay_buffer_ctrl.  |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface delay_buffer_ctrl_if
    import delay_buf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = c_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = c_DATA_WIDTH
);
    logic                     in_valid;
    logic [DATA_WIDTH-1:0]    din;
    logic [ADDRESS_WIDTH-1:0] offset;
    logic                     restart;
    logic [DATA_WIDTH-1:0]    dout;
    logic                     out_valid;
    logic [1:0]               state;

    modport master (
        output in_valid, din, offset, restart,
        input  dout, out_valid, state
    );

    modport slave (
        input  in_valid, din, offset, restart,
        output dout, out_valid, state
    );
endinterface
`default_nettype wire

// File: rtl/delay_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : delay_mem                                                   |
// | Desc   : Simple dual-port memory: one synchronous write port, one    |
// |          registered read port (read-before-write). Array contents    |
// |          are never reset; only the read register is.                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module delay_mem
    import delay_buf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = c_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = c_DATA_WIDTH
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_wr_en,
    input  wire logic [ADDRESS_WIDTH-1:0] i_wr_addr,
    input  wire logic [DATA_WIDTH-1:0]    i_wr_data,
    input  wire logic                     i_rd_en,
    input  wire logic [ADDRESS_WIDTH-1:0] i_rd_addr,
    output logic      [DATA_WIDTH-1:0]    o_rd_data
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDRESS_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Write port: storage only, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: register updates only on an issued read, so it keeps the last sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule
`default_nettype wire

// File: rtl/delay_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : delay_buffer_ctrl                                           |
// | Desc   : Circular-buffer delay line. Each strobe writes one sample;  |
// |          once offset_q samples are stored, each strobe also reads    |
// |          the sample written offset_q strobes earlier (1-cycle lat.). |
// |          Build option DELAY_BUF_HOLD_EN: dout holds the last valid   |
// |          sample while out_valid is low (otherwise dout is 0).        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module delay_buffer_ctrl
    import delay_buf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = c_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = c_DATA_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    delay_buffer_ctrl_if.slave bus
);
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
    logic [ADDRESS_WIDTH-1:0] w_wr_ptr_nxt;
    logic [ADDRESS_WIDTH-1:0] r_fill_cnt;
    logic [ADDRESS_WIDTH-1:0] w_fill_cnt_nxt;
    logic [ADDRESS_WIDTH-1:0] r_offset_q;
    logic [ADDRESS_WIDTH-1:0] w_offset_nxt;
    logic [ADDRESS_WIDTH-1:0] w_offset_clamped;
    logic [ADDRESS_WIDTH-1:0] w_rd_addr;
    logic                     w_wr_en;
    logic                     w_rd_en;
    logic                     r_out_valid;
    logic [DATA_WIDTH-1:0]    w_rd_data;

    // A zero delay would read the address being written; treat it as 1.
    assign w_offset_clamped = (bus.offset == '0) ? ADDRESS_WIDTH'(1) : bus.offset;
    // Modular subtraction: wraps naturally at ADDRESS_WIDTH bits.
    assign w_rd_addr        = r_wr_ptr - r_offset_q;

    // State, pointer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_offset_q  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_fill_cnt  <= w_fill_cnt_nxt;
            r_offset_q  <= w_offset_nxt;
            r_out_valid <= w_rd_en;
        end
    end

    // Next-state and strobe decode; restart wins over a same-cycle strobe.
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_fill_cnt_nxt = r_fill_cnt;
        w_offset_nxt   = r_offset_q;
        w_wr_en        = 1'b0;
        w_rd_en        = 1'b0;
        if (bus.restart) begin
            w_state_nxt    = IDLE;
            w_wr_ptr_nxt   = '0;
            w_fill_cnt_nxt = '0;
        end else if (bus.in_valid) begin
            w_wr_en      = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + ADDRESS_WIDTH'(1);
            case (r_state)
                IDLE: begin
                    w_offset_nxt   = w_offset_clamped;
                    w_fill_cnt_nxt = ADDRESS_WIDTH'(1);
                    w_state_nxt    = (w_offset_clamped == ADDRESS_WIDTH'(1)) ? RUN : FILL;
                end
                FILL: begin
                    w_fill_cnt_nxt = r_fill_cnt + ADDRESS_WIDTH'(1);
                    if (w_fill_cnt_nxt == r_offset_q) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    w_rd_en = 1'b1;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    delay_mem #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.din),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

`ifdef DELAY_BUF_HOLD_EN
    // Read register only changes on a read, so it already holds the last sample.
    assign bus.dout = w_rd_data;
`else
    assign bus.dout = r_out_valid ? w_rd_data : '0;
`endif
    assign bus.out_valid = r_out_valid;
    assign bus.state     = r_state;
endmodule
`default_nettype wire
